// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle between the register-read stage and the multi-cycle ALU.
// Latency: none (wires only).
// Backpressure: requester holds in_valid and operands until in_ready is seen high at an edge.
interface alu_mc_if #(
  parameter int data_width = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            alu_in;
  logic [data_width-1:0] data_rs1;
  logic [data_width-1:0] data_rs2;
  logic                  out_valid;
  logic [data_width-1:0] data;
  logic                  zero;

  modport master (
    output in_valid, alu_in, data_rs1, data_rs2,
    input  in_ready, out_valid, data, zero
  );

  modport slave (
    input  in_valid, alu_in, data_rs1, data_rs2,
    output in_ready, out_valid, data, zero
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: execute-stage ALU; single-cycle logic/arith/shift/compare, iterative MUL/MULHU, optional DIV/REM (ALU_MC_DIV_EN).
// Latency: result visible the cycle after the accept edge for single-cycle ops; data_width edges later for iterative ops.
// Backpressure: in_ready is high only in IDLE (decoded from state alone); requester holds in_valid and operands.
module alu_mc #(
  parameter int data_width = 32
) (
  input logic   clk,
  input logic   rst_n,
  alu_mc_if.slave bus
);

  localparam int W  = data_width;
  localparam int SW = $clog2(W);
  localparam int CW = $clog2(W + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_SRA   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;

`ifdef ALU_MC_DIV_EN
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_MUL} state_t;
`endif

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  // sel: MULHU (high half) for the multiplier, REM/REMU for the divider
  logic           sel, sel_n;
  // acc: product high half / partial remainder
  logic [W-1:0]   acc, acc_n;
  // shreg: multiplier bits consumed LSB first / dividend shifted out MSB first, quotient shifted in
  logic [W-1:0]   shreg, shreg_n;
  // opnd: multiplicand / divisor magnitude
  logic [W-1:0]   opnd, opnd_n;
  logic [W-1:0]   data_q, data_n;
  logic           zero_q, zero_n;
  logic           valid_q, valid_n;
  logic [W-1:0]   res;
  logic           load;

  logic [SW-1:0]  shamt;
  logic           slt_s;
  logic           slt_u;
  logic [W-1:0]   sc_res;
  logic           is_mul;

  logic [W:0]     mul_sum;
  logic [W-1:0]   mul_acc;
  logic [W-1:0]   mul_lo;

`ifdef ALU_MC_DIV_EN
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic           q_neg, q_neg_n;
  logic           r_neg, r_neg_n;
  logic           is_div;
  logic           div_signed;
  logic           div_by_zero;
  logic           div_ovf;
  logic [W-1:0]   rs1_mag;
  logic [W-1:0]   rs2_mag;
  logic [W:0]     div_trial;
  logic           div_fit;
  logic [W-1:0]   div_rem;
  logic [W-1:0]   div_quo;
  logic [W-1:0]   div_res;
`endif

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = valid_q;
  assign bus.data      = data_q;
  assign bus.zero      = zero_q;

  assign shamt  = bus.data_rs2[SW-1:0];
  assign slt_s  = $signed(bus.data_rs1) < $signed(bus.data_rs2);
  assign slt_u  = bus.data_rs1 < bus.data_rs2;
  assign is_mul = (bus.alu_in == OP_MUL) || (bus.alu_in == OP_MULHU);

  // One shift-add step: conditionally add the multiplicand, then shift {carry, acc, shreg} right by one
  assign mul_sum = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : {(W+1){1'b0}});
  assign mul_acc = mul_sum[W:1];
  assign mul_lo  = {mul_sum[0], shreg[W-1:1]};

`ifdef ALU_MC_DIV_EN
  // DIV and REM have bit0 clear; DIVU and REMU have bit0 set
  assign is_div      = (bus.alu_in[3:2] == 2'b11);
  assign div_signed  = ~bus.alu_in[0];
  assign div_by_zero = (bus.data_rs2 == '0);
  assign div_ovf     = div_signed && (bus.data_rs1 == MOST_NEG) && (bus.data_rs2 == '1);
  // Negating the most-negative value leaves it unchanged, which is its correct unsigned magnitude
  assign rs1_mag     = (div_signed && bus.data_rs1[W-1]) ? -bus.data_rs1 : bus.data_rs1;
  assign rs2_mag     = (div_signed && bus.data_rs2[W-1]) ? -bus.data_rs2 : bus.data_rs2;

  // One restoring step: shift the next dividend bit into the remainder and subtract if it fits
  assign div_trial = {acc, shreg[W-1]} - {1'b0, opnd};
  assign div_fit   = ~div_trial[W];
  assign div_rem   = div_fit ? div_trial[W-1:0] : {acc[W-2:0], shreg[W-1]};
  assign div_quo   = {shreg[W-2:0], div_fit};
  assign div_res   = sel ? (r_neg ? -div_rem : div_rem)
                         : (q_neg ? -div_quo : div_quo);
`endif

  // Single-cycle result decode; opcodes with no single-cycle meaning return zero
  always_comb begin
    sc_res = '0;
    case (bus.alu_in)
      OP_AND:  sc_res = bus.data_rs1 & bus.data_rs2;
      OP_OR:   sc_res = bus.data_rs1 | bus.data_rs2;
      OP_ADD:  sc_res = bus.data_rs1 + bus.data_rs2;
      OP_XOR:  sc_res = bus.data_rs1 ^ bus.data_rs2;
      OP_SUB:  sc_res = bus.data_rs1 - bus.data_rs2;
      OP_SLL:  sc_res = bus.data_rs1 << shamt;
      OP_SRL:  sc_res = bus.data_rs1 >> shamt;
      OP_SRA:  sc_res = $signed(bus.data_rs1) >>> shamt;
      OP_SLT:  sc_res = {{(W-1){1'b0}}, slt_s};
      OP_SLTU: sc_res = {{(W-1){1'b0}}, slt_u};
      default: sc_res = '0;
    endcase
  end

  // Next-state, iteration datapath and result-register load
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel;
    acc_n   = acc;
    shreg_n = shreg;
    opnd_n  = opnd;
    res     = data_q;
    load    = 1'b0;
`ifdef ALU_MC_DIV_EN
    q_neg_n = q_neg;
    r_neg_n = r_neg;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (is_mul) begin
            state_n = ST_MUL;
            cnt_n   = CW'(W);
            sel_n   = bus.alu_in[0];
            acc_n   = '0;
            shreg_n = bus.data_rs1;
            opnd_n  = bus.data_rs2;
          end
`ifdef ALU_MC_DIV_EN
          else if (is_div) begin
            if (div_by_zero) begin
              load = 1'b1;
              res  = bus.alu_in[1] ? bus.data_rs1 : '1;
            end else if (div_ovf) begin
              load = 1'b1;
              res  = bus.alu_in[1] ? '0 : bus.data_rs1;
            end else begin
              state_n = ST_DIV;
              cnt_n   = CW'(W);
              sel_n   = bus.alu_in[1];
              acc_n   = '0;
              shreg_n = rs1_mag;
              opnd_n  = rs2_mag;
              q_neg_n = div_signed && (bus.data_rs1[W-1] ^ bus.data_rs2[W-1]);
              r_neg_n = div_signed && bus.data_rs1[W-1];
            end
          end
`endif
          else begin
            load = 1'b1;
            res  = sc_res;
          end
        end
      end
      ST_MUL: begin
        cnt_n   = cnt - CW'(1);
        acc_n   = mul_acc;
        shreg_n = mul_lo;
        if (cnt == CW'(1)) begin
          load    = 1'b1;
          res     = sel ? mul_acc : mul_lo;
          state_n = ST_IDLE;
        end
      end
`ifdef ALU_MC_DIV_EN
      ST_DIV: begin
        cnt_n   = cnt - CW'(1);
        acc_n   = div_rem;
        shreg_n = div_quo;
        if (cnt == CW'(1)) begin
          load    = 1'b1;
          res     = div_res;
          state_n = ST_IDLE;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase

    valid_n = load;
    data_n  = load ? res : data_q;
    zero_n  = load ? (res == '0) : zero_q;
  end

  // State, datapath and output registers; reset discards any in-flight iteration
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sel     <= 1'b0;
      acc     <= '0;
      shreg   <= '0;
      opnd    <= '0;
      data_q  <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
`ifdef ALU_MC_DIV_EN
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sel     <= sel_n;
      acc     <= acc_n;
      shreg   <= shreg_n;
      opnd    <= opnd_n;
      data_q  <= data_n;
      zero_q  <= zero_n;
      valid_q <= valid_n;
`ifdef ALU_MC_DIV_EN
      q_neg   <= q_neg_n;
      r_neg   <= r_neg_n;
`endif
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed table plus randomized ops against an arithmetic reference, for widths 32 and 16.
// Latency: expects single-cycle results one sample after accept, iterative ones data_width+1 samples after.
// Backpressure: checks in_ready stays low exactly data_width samples for iterative ops and that held requests wait.
module tb_alu_mc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_mc_if #(.data_width(32)) i32 ();
  alu_mc_if #(.data_width(16)) i16 ();

  alu_mc #(.data_width(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(i32));
  alu_mc #(.data_width(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16));

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int          w;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int w, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] exp, int busy);
    vec_t v;
    v.w = w; v.op = op; v.a = a; v.b = b; v.exp = exp; v.busy = busy;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on w-bit values
  function automatic logic [31:0] model(int w, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] m, ua, ub, r;
    longint      sa, sb;
    int          sh;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    sa = $signed(ua << (64 - w)) >>> (64 - w);
    sb = $signed(ub << (64 - w)) >>> (64 - w);
    sh = int'(ub % 64'(w));
    r  = 64'd0;
    case (op)
      4'b0000: r = ua & ub;
      4'b0001: r = ua | ub;
      4'b0010: r = ua + ub;
      4'b0011: r = ua ^ ub;
      4'b0110: r = ua - ub;
      4'b0111: r = ua << sh;
      4'b0100: r = ua >> sh;
      4'b0101: r = 64'(sa >>> sh);
      4'b1000: r = {63'd0, sa < sb};
      4'b1001: r = {63'd0, ua < ub};
      4'b1010: r = ua * ub;
      4'b1011: r = (ua * ub) >> w;
`ifdef ALU_MC_DIV_EN
      4'b1100: r = (ub == 0) ? m  : 64'(sa / sb);
      4'b1101: r = (ub == 0) ? m  : ua / ub;
      4'b1110: r = (ub == 0) ? ua : 64'(sa % sb);
      4'b1111: r = (ub == 0) ? ua : ua % ub;
`endif
      default: r = 64'd0;
    endcase
    return 32'(r & m);
  endfunction

  // Reference: number of samples in_ready is low after the accept edge
  function automatic int model_busy(int w, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] m, ua, ub;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    if (op == 4'b1010 || op == 4'b1011) return w;
`ifdef ALU_MC_DIV_EN
    if (op[3:2] == 2'b11) begin
      if (ub == 0) return 0;
      if (!op[0] && ua == (64'd1 << (w - 1)) && ub == m) return 0;
      return w;
    end
`endif
    return 0;
  endfunction

  function automatic logic s_ov(int w);
    return (w == 32) ? i32.out_valid : i16.out_valid;
  endfunction
  function automatic logic s_rdy(int w);
    return (w == 32) ? i32.in_ready : i16.in_ready;
  endfunction
  function automatic logic s_zero(int w);
    return (w == 32) ? i32.zero : i16.zero;
  endfunction
  function automatic logic [31:0] s_data(int w);
    return (w == 32) ? i32.data : {16'd0, i16.data};
  endfunction

  task automatic drive(int w, logic v, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    if (w == 32) begin
      i32.in_valid = v; i32.alu_in = op; i32.data_rs1 = a; i32.data_rs2 = b;
    end else begin
      i16.in_valid = v; i16.alu_in = op; i16.data_rs1 = a[15:0]; i16.data_rs2 = b[15:0];
    end
  endtask

  task automatic run_op(string name, int w, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                        output logic [31:0] d, output logic z, output int lat, output int busy);
    @(negedge clk);
    check({name, " ready"}, {31'd0, s_rdy(w)}, 32'd1);
    drive(w, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, op, a, b);
    d = 'x; z = 1'bx; lat = -1; busy = 0;
    for (int k = 1; k <= 3 * w; k++) begin
      if (s_ov(w)) begin
        lat = k; d = s_data(w); z = s_zero(w);
        break;
      end
      if (!s_rdy(w)) busy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic verify(string name, int w, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] exp, int eb);
    logic [31:0] d;
    logic        z;
    int          lat, busy;
    run_op(name, w, op, a, b, d, z, lat, busy);
    check({name, " data"}, d, exp);
    check({name, " zero"}, {31'd0, z}, {31'd0, exp == 32'd0});
    check({name, " busy"}, busy, eb);
    check({name, " latency"}, lat, (eb == 0) ? 1 : w + 1);
    @(posedge clk); #1;
    check({name, " pulse"}, {31'd0, s_ov(w)}, 32'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          w, seen;

    rst_n = 1'b0;
    drive(32, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(16, 1'b0, 4'd0, 32'd0, 32'd0);

    tbl.push_back(mk(32, 4'b0010, 32'd5,        32'd7,        32'd12,        0));
    tbl.push_back(mk(32, 4'b0110, 32'd7,        32'd7,        32'd0,         0));
    tbl.push_back(mk(32, 4'b0101, 32'h80000000, 32'h21,       32'hC0000000,  0));
    tbl.push_back(mk(32, 4'b0111, 32'd1,        32'h3F,       32'h80000000,  0));
    tbl.push_back(mk(32, 4'b1000, 32'hFFFFFFFF, 32'd1,        32'd1,         0));
    tbl.push_back(mk(32, 4'b1001, 32'd1,        32'hFFFFFFFF, 32'd1,         0));
    tbl.push_back(mk(32, 4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32));
    tbl.push_back(mk(32, 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32));
`ifdef ALU_MC_DIV_EN
    tbl.push_back(mk(32, 4'b1100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32));
    tbl.push_back(mk(32, 4'b1110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32));
    tbl.push_back(mk(32, 4'b1101, 32'd9,        32'd0,        32'hFFFFFFFF,  0));
    tbl.push_back(mk(32, 4'b1111, 32'd9,        32'd0,        32'd9,         0));
    tbl.push_back(mk(32, 4'b1100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  0));
    tbl.push_back(mk(32, 4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'd0,         0));
`else
    tbl.push_back(mk(32, 4'b1100, 32'd9,        32'd3,        32'd0,         0));
    tbl.push_back(mk(32, 4'b1111, 32'd9,        32'd3,        32'd0,         0));
`endif
    tbl.push_back(mk(16, 4'b1000, 32'h8000,     32'h0001,     32'd1,         0));
    tbl.push_back(mk(16, 4'b1010, 32'h1234,     32'h0010,     32'h2340,     16));
    tbl.push_back(mk(16, 4'b1011, 32'hFFFF,     32'hFFFF,     32'hFFFE,     16));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", {31'd0, i32.out_valid}, 32'd0);
    check("reset data",      i32.data, 32'd0);
    check("reset zero",      {31'd0, i32.zero}, 32'd1);
    check("reset in_ready",  {31'd0, i32.in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle out_valid",  {31'd0, i32.out_valid}, 32'd0);

    // Directed table
    foreach (tbl[i])
      verify($sformatf("tbl%0d", i), tbl[i].w, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].busy);

    // Back-to-back single-cycle ops give consecutive pulses
    @(negedge clk);
    drive(32, 1'b1, 4'b0010, 32'd5, 32'd7);
    @(posedge clk); #1;
    check("b2b add valid", {31'd0, i32.out_valid}, 32'd1);
    check("b2b add data",  i32.data, 32'd12);
    drive(32, 1'b1, 4'b0110, 32'd7, 32'd7);
    @(posedge clk); #1;
    check("b2b sub valid", {31'd0, i32.out_valid}, 32'd1);
    check("b2b sub data",  i32.data, 32'd0);
    check("b2b sub zero",  {31'd0, i32.zero}, 32'd1);
    drive(32, 1'b1, 4'b0101, 32'h80000000, 32'h21);
    @(posedge clk); #1;
    check("b2b sra valid", {31'd0, i32.out_valid}, 32'd1);
    check("b2b sra data",  i32.data, 32'hC0000000);
    drive(32, 1'b0, 4'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    check("b2b end valid", {31'd0, i32.out_valid}, 32'd0);

    // Request held during MUL must wait and be taken right after the MUL result
    @(negedge clk);
    drive(32, 1'b1, 4'b1010, 32'd3, 32'd5);
    @(posedge clk); #1;
    drive(32, 1'b1, 4'b0010, 32'd1, 32'd2);
    for (int k = 0; k < 100 && !i32.out_valid; k++) begin
      @(posedge clk); #1;
    end
    check("hold mul data", i32.data, 32'd15);
    @(posedge clk); #1;
    check("hold add valid", {31'd0, i32.out_valid}, 32'd1);
    check("hold add data",  i32.data, 32'd3);
    drive(32, 1'b0, 4'd0, 32'd0, 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a MUL discards it
    @(negedge clk);
    drive(32, 1'b1, 4'b1010, 32'd7, 32'd9);
    @(posedge clk); #1;
    drive(32, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid-reset data",     i32.data, 32'd0);
    check("mid-reset zero",     {31'd0, i32.zero}, 32'd1);
    check("mid-reset in_ready", {31'd0, i32.in_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (i32.out_valid) seen++;
      @(posedge clk); #1;
    end
    check("mid-reset no out_valid", seen, 0);

    // Randomized ops against the reference
    for (int i = 0; i < 80; i++) begin
      w  = (i % 4 == 3) ? 16 : 32;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'd1 << (w - 1);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = $urandom_range(0, 40);
        default: b = $urandom;
      endcase
      verify($sformatf("rnd%0d op%0h", i, op), w, op, a, b, model(w, op, a, b), model_busy(w, op, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
